alu_arbiter: RTL

Round-robin arbiter that shares one `alucon` ALU instance between `NUM_REQ` requesters. It accepts one request at a time, latches its operands, pulses the ALU `enable`, waits for ALU `valid`, and returns `out_put` to the winning requester. It sits between the requesting blocks and the ALU, driving `op1`, `op2`, `fn` and `enable`, and consuming `out_put` and `valid`.

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter that shares one ALU between NUM_REQ requesters.
//   One request is accepted at a time. The arbiter latches the winner's
//   operands, pulses alu_enable, waits for alu_valid and returns the result
//   to the winner.
//   State sequence: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Optional feature (compile-time macro ALU_ARB_TIMEOUT_EN):
//   When defined, WAIT gives up after TIMEOUT cycles without alu_valid.
//   The response is then returned with resp_err=1 and resp_data=0.
//   When undefined, WAIT waits indefinitely and resp_err is tied to 0.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   req_valid    per-requester request
//   req_op1/2    packed operands; requester i at [i*WIDTH +: WIDTH]
//   req_fn       packed function codes; requester i at [i*FN_W +: FN_W]
//   req_ready    one-hot accept pulse (combinational, IDLE only)
//   resp_valid   one-hot response pulse
//   resp_data    result, qualified by any resp_valid bit
//   resp_err     timeout flag, qualified by resp_valid
//   alu_op1/2    registered ALU operands
//   alu_fn       registered ALU function code
//   alu_enable   one-cycle ALU start pulse
//   alu_out_put  ALU result
//   alu_valid    ALU result valid
//   busy         high in every state except IDLE
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int FN_W    = 4,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*WIDTH-1:0] req_op2,
  input  logic [NUM_REQ*FN_W-1:0]  req_fn,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [RES_W-1:0]         resp_data,
  output logic                     resp_err,
  output logic [WIDTH-1:0]         alu_op1,
  output logic [WIDTH-1:0]         alu_op2,
  output logic [FN_W-1:0]          alu_fn,
  output logic                     alu_enable,
  input  logic [RES_W-1:0]         alu_out_put,
  input  logic                     alu_valid,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign resp_err = 1'b0;
`endif

  // Search upward from ptr with wrap; the first requesting index wins.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // The accept pulse follows the live req_valid; it is masked while reset is
  // asserted so every output reads 0 during reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && rst && win_found)
      req_ready[win_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_fn     <= '0;
      alu_enable <= 1'b0;
      busy       <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      resp_err   <= 1'b0;
`endif
    end else begin
      // Pulses drop by default and are raised only on their one cycle.
      alu_enable <= 1'b0;
      resp_valid <= '0;
      unique case (state)
        IDLE: begin
          // alu_valid is ignored here; only an accept moves the FSM.
          if (win_found) begin
            alu_op1    <= req_op1[win_idx*WIDTH +: WIDTH];
            alu_op2    <= req_op2[win_idx*WIDTH +: WIDTH];
            alu_fn     <= req_fn[win_idx*FN_W +: FN_W];
            gnt        <= win_idx;
            alu_enable <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the timeout cycle takes priority.
          if (alu_valid) begin
            resp_data       <= alu_out_put;
            resp_valid[gnt] <= 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
            resp_err        <= 1'b0;
`endif
            state           <= RESP;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            // The counter would reach TIMEOUT at this edge.
            resp_data       <= '0;
            resp_err        <= 1'b1;
            resp_valid[gnt] <= 1'b1;
            state           <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          // Move the priority past the requester just served.
          ptr   <= (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
